// File: rtl/ssd_monitor.sv
// Seven-segment display bus monitor: recovers the four displayed characters
// from the multiplexed segment/anode lines and reports digit status, frames and stalls.
module ssd_monitor #(
    parameter int STABLE  = 16,
    parameter int TIMEOUT = 400000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  C,
    input  logic [3:0]  AN,
    output logic [15:0] digits,
    output logic [7:0]  status,
    output logic        frame,
    output logic        stalled
);

    localparam int DW = $clog2(STABLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_HEX     = 2'b01,
        ST_BLANK   = 2'b10,
        ST_INVALID = 2'b11
    } digit_status_e;

    typedef struct packed {
        digit_status_e st;
        logic [3:0]    value;
    } decode_t;

    // Segment lines are active-low with C[6]=a ... C[0]=g.
    function automatic decode_t decode(input logic [6:0] c);
        decode_t r;
        r.st    = ST_HEX;
        r.value = 4'h0;
        case (c)
            7'h01: r.value = 4'h0;
            7'h4F: r.value = 4'h1;
            7'h12: r.value = 4'h2;
            7'h06: r.value = 4'h3;
            7'h4C: r.value = 4'h4;
            7'h24: r.value = 4'h5;
            7'h20: r.value = 4'h6;
            7'h0F: r.value = 4'h7;
            7'h00: r.value = 4'h8;
            7'h04: r.value = 4'h9;
            7'h08: r.value = 4'hA;
            7'h60: r.value = 4'hB;
            7'h31: r.value = 4'hC;
            7'h42: r.value = 4'hD;
            7'h30: r.value = 4'hE;
            7'h38: r.value = 4'hF;
            7'h7F: r.st    = ST_BLANK;
            default: r.st  = ST_INVALID;
        endcase
        return r;
    endfunction

    logic [10:0]   pair_q,   pair_d;
    logic [DW-1:0] dwell_q,  dwell_d;
    logic [15:0]   digits_q, digits_d;
    logic [7:0]    status_q, status_d;
    logic [3:0]    seen_q,   seen_d;
    logic [TW-1:0] stall_q,  stall_d;
    logic          frame_q,  frame_d;

    logic          same;
    logic          one_hot;
    logic          capture;
    logic [3:0]    sel;
    logic [3:0]    seen_all;
    decode_t       dec;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves a latch.
        pair_d   = {AN, C};
        dwell_d  = DW'(1);
        digits_d = digits_q;
        status_d = status_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        stall_d  = stall_q;

        sel      = ~AN;
        one_hot  = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
        dec      = decode(C);
        seen_all = seen_q | sel;

        // A zero dwell count means nothing valid has been sampled since reset.
        same = (dwell_q != '0) && (pair_d == pair_q);
        if (same) begin
            dwell_d = (dwell_q == DW'(STABLE)) ? dwell_q : dwell_q + DW'(1);
        end

        capture = one_hot && same && (dwell_q == DW'(STABLE - 1));

        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    status_d[2*i +: 2] = dec.st;
                    if (dec.st != ST_INVALID) begin
                        digits_d[4*i +: 4] = dec.value;
                    end
                end
            end
            if (seen_all == 4'hF) begin
                frame_d = 1'b1;
                seen_d  = 4'h0;
            end else begin
                seen_d  = seen_all;
            end
            stall_d = '0;
        end else if (stall_q != TW'(TIMEOUT)) begin
            stall_d = stall_q + TW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pair_q   <= '0;
            dwell_q  <= '0;
            digits_q <= '0;
            status_q <= '0;
            seen_q   <= '0;
            stall_q  <= '0;
            frame_q  <= 1'b0;
        end else begin
            pair_q   <= pair_d;
            dwell_q  <= dwell_d;
            digits_q <= digits_d;
            status_q <= status_d;
            seen_q   <= seen_d;
            stall_q  <= stall_d;
            frame_q  <= frame_d;
        end
    end

    assign digits  = digits_q;
    assign status  = status_q;
    assign frame   = frame_q;
    assign stalled = (stall_q == TW'(TIMEOUT));

endmodule

// File: doc/ssd_monitor.md
# ssd_monitor

Receiving-end monitor for the multiplexed 4-digit seven-segment display bus: it watches the segment lines and anode selects as driven to the board, then recovers the four displayed characters. The monitor checks that each digit is held stable, decodes each segment pattern back to a hex value or blank, and reports per-digit status, frame completion and scan stalls. It sits beside the display driver on the same clock and is used for on-board self-check and bench verification of display logic.

## Interface
Parameters:
- STABLE, 16: number of consecutive identical samples of {AN,C} needed to accept a digit (≥2).
- TIMEOUT, 400000: cycles without any capture before `stalled` asserts (≥1).

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- C  input  7  segment lines, active-low; C[6]=a … C[0]=g.
- AN  input  4  anode selects, active-low; AN[3]=leftmost digit, AN[0]=rightmost.
- digits  output  16  recovered values; digit i at [4i+3:4i], matching AN[i].
- status  output  8  per-digit status at [2i+1:2i]: 00 never seen, 01 hex, 10 blank, 11 invalid.
- frame  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
- stalled  output  1  high while no capture has occurred for TIMEOUT cycles.

## Operation
- {AN,C} is sampled every clock edge; a dwell counter counts consecutive identical samples and resets to 1 on any change.
- A capture is eligible only if AN is one-hot-low (exactly one bit 0). All-high or multi-low AN never captures and only advances the stall counter.
- A capture fires once per dwell, when the count reaches STABLE. No re-capture occurs until the pair changes, however long it is held.
- Decode uses C, active-low. The hex patterns are:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38
- Decode results and their effect on the selected digit:
  - Hex pattern: status=01 and the value is written.
  - C=7F (blank): status=10 and the value is written as 0.
  - Any other pattern: status=11 and the value is unchanged.
- Frame tracking: a 4-bit seen-set records the digits captured since the last frame.
  - When a capture completes the set, `frame` pulses and the set clears. The completing digit is not carried into the next set.
  - Recapturing an already-seen digit does not change the set.
- Stall tracking:
  - The stall counter saturates at TIMEOUT and clears on every capture.
  - `stalled` = (counter == TIMEOUT).
  - `stalled` drops on the edge that performs a capture.

## Timing
- Reset (synchronous) sets all outputs and all internal state to 0: digits=0, status=0, frame=0, stalled=0, dwell count=0, seen-set=0, stall counter=0.
- Capture latency:
  - If a pair is first sampled at edge k and held, `digits`/`status` update at edge k+STABLE-1.
  - `frame` is high for exactly the cycle following that edge.
- Rejected dwells:
  - A pair held for only STABLE-1 samples produces no capture.
  - An identical pair re-presented after a different pair starts a new dwell, which is a new capture.
- Reset mid-dwell discards the partial count. A pair held across reset deassertion counts from the first edge with reset low.
- Reset has priority over a capture scheduled on the same edge.
- Stall timing:
  - `stalled` rises at the edge where the counter reaches TIMEOUT, i.e. TIMEOUT edges after the last capture or after reset release.
  - The stall counter keeps running during an uncaptured dwell.

## Test plan
- Reset, then AN=1110, C=12 held 20 cycles (STABLE=16) -> digits[3:0]=2 and status[1:0]=01 from the 16th sample edge; unchanged before it; no second capture while the pair is held.
- AN=1101, C=4F held 15 cycles, then C=01 held 20 cycles -> only digit 1 captured with value 0, status=01; value 1 never appears.
- Scan with each step held 20 cycles: AN=0111/C=7F, AN=1011/C=7F, AN=1101/C=4F, AN=1110/C=01 -> status=8'b10_10_01_01, digits=16'h0010, one `frame` pulse after the 4th capture; a second identical scan gives exactly one more pulse.
- AN=1110, C=55 held 20 cycles after a valid '2' -> status[1:0]=11, digits[3:0] stays 2.
- With TIMEOUT=100: AN=1100 held 50 cycles, then AN=1111 held 60 cycles -> no capture; `stalled` rises 100 edges after reset release; a valid capture on AN=0111 clears `stalled` on the capture edge.
- AN=1011, C=06 for 10 cycles, reset for 1 cycle, hold 15 more cycles -> no capture; holding to 16 post-reset samples captures digit 2 = 3.
